// File: rtl/biriscv_issue_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : biriscv_issue_hazard_pkg
// Brief   : Shared register-index width and forwarding-select encoding.
// Revision: 1.0
// ============================================================================
package biriscv_issue_hazard_pkg;

  localparam int c_REG_W = 5;

  typedef enum logic [2:0] {
    FWD_ZERO = 3'd0,
    FWD_E1   = 3'd1,
    FWD_E2   = 3'd2,
    FWD_WB   = 3'd3,
    FWD_RF   = 3'd4
  } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/biriscv_issue_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : biriscv_issue_fwd_mux
// Brief   : Per-source operand bypass select and source-operand hazard.
// Revision: 1.0
// ============================================================================
module biriscv_issue_fwd_mux
  import biriscv_issue_hazard_pkg::*;
#(
  parameter bit SUPPORT_LOAD_BYPASS = 1'b1,
  parameter bit SUPPORT_MUL_BYPASS  = 1'b1
) (
  input  logic [c_REG_W-1:0] rs_i,
  input  logic [31:0]        rf_data_i,
  input  logic               load_e1_i,
  input  logic               mul_e1_i,
  input  logic [c_REG_W-1:0] rd_e1_i,
  input  logic [31:0]        alu_result_e1_i,
  input  logic               load_e2_i,
  input  logic               mul_e2_i,
  input  logic [c_REG_W-1:0] rd_e2_i,
  input  logic [31:0]        result_e2_i,
  input  logic [c_REG_W-1:0] rd_wb_i,
  input  logic [31:0]        result_wb_i,
  input  logic               div_busy_i,
  input  logic [c_REG_W-1:0] div_rd_i,
  output logic [31:0]        value_o,
  output logic               hazard_o
);

  logic     w_nonzero;
  logic     w_hit_e1;
  logic     w_hit_e2;
  logic     w_hit_wb;
  logic     w_e2_ready;
  fwd_sel_e w_sel;

  assign w_nonzero  = (rs_i != '0);
  assign w_hit_e1   = (rs_i == rd_e1_i);
  assign w_hit_e2   = (rs_i == rd_e2_i);
  assign w_hit_wb   = (rs_i == rd_wb_i);
  // E2 result is only usable early if this build bypasses its producer class
  assign w_e2_ready = (SUPPORT_LOAD_BYPASS | ~load_e2_i) &
                      (SUPPORT_MUL_BYPASS  | ~mul_e2_i);

  always_comb begin
    w_sel = FWD_RF;
    if (!w_nonzero)
      w_sel = FWD_ZERO;
    else if (w_hit_e1 & ~load_e1_i & ~mul_e1_i)
      w_sel = FWD_E1;
    else if (w_hit_e2 & w_e2_ready)
      w_sel = FWD_E2;
    else if (w_hit_wb)
      w_sel = FWD_WB;
  end

  always_comb begin
    value_o = rf_data_i;
    case (w_sel)
      FWD_ZERO: value_o = 32'd0;
      FWD_E1:   value_o = alu_result_e1_i;
      FWD_E2:   value_o = result_e2_i;
      FWD_WB:   value_o = result_wb_i;
      default:  value_o = rf_data_i;
    endcase
  end

  assign hazard_o = w_nonzero & (
                      (w_hit_e1 & (load_e1_i | mul_e1_i)) |
                      (w_hit_e2 & ~w_e2_ready) |
                      (div_busy_i & (rs_i == div_rd_i)));

endmodule
`default_nettype wire

// File: rtl/biriscv_issue_hazard.sv
`default_nettype none
// ============================================================================
// Module  : biriscv_issue_hazard
// Brief   : Issue hazard detection, operand bypass, divide scoreboard and
//           saturating hazard-cycle counter.
// Revision: 1.0
// ============================================================================
module biriscv_issue_hazard
  import biriscv_issue_hazard_pkg::*;
#(
  parameter bit SUPPORT_LOAD_BYPASS = 1'b1,
  parameter bit SUPPORT_MUL_BYPASS  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  input  logic               issue_stall_i,
  input  logic               issue_div_i,
  input  logic               issue_rd_valid_i,
  input  logic [c_REG_W-1:0] issue_rd_i,
  input  logic [c_REG_W-1:0] issue_rs1_i,
  input  logic [c_REG_W-1:0] issue_rs2_i,
  input  logic [31:0]        rf_ra_i,
  input  logic [31:0]        rf_rb_i,
  input  logic               take_interrupt_i,
  input  logic               load_e1_i,
  input  logic               mul_e1_i,
  input  logic [c_REG_W-1:0] rd_e1_i,
  input  logic [31:0]        alu_result_e1_i,
  input  logic               load_e2_i,
  input  logic               mul_e2_i,
  input  logic [c_REG_W-1:0] rd_e2_i,
  input  logic [31:0]        result_e2_i,
  input  logic [c_REG_W-1:0] rd_wb_i,
  input  logic [31:0]        result_wb_i,
  input  logic               div_complete_i,
  input  logic               squash_e1_e2_i,
  input  logic               perf_clr_i,
  output logic               issue_hazard_o,
  output logic [31:0]        operand_ra_o,
  output logic [31:0]        operand_rb_o,
  output logic               div_busy_o,
  output logic [31:0]        hazard_cycles_o
);

  logic               r_div_busy;
  logic [c_REG_W-1:0] r_div_rd;
  logic [31:0]        r_hazard_cycles;
  logic               w_haz_ra;
  logic               w_haz_rb;
  logic               w_hazard;
  logic               w_issue_fire;

  biriscv_issue_fwd_mux #(
    .SUPPORT_LOAD_BYPASS (SUPPORT_LOAD_BYPASS),
    .SUPPORT_MUL_BYPASS  (SUPPORT_MUL_BYPASS)
  ) u_fwd_ra (
    .rs_i            (issue_rs1_i),
    .rf_data_i       (rf_ra_i),
    .load_e1_i       (load_e1_i),
    .mul_e1_i        (mul_e1_i),
    .rd_e1_i         (rd_e1_i),
    .alu_result_e1_i (alu_result_e1_i),
    .load_e2_i       (load_e2_i),
    .mul_e2_i        (mul_e2_i),
    .rd_e2_i         (rd_e2_i),
    .result_e2_i     (result_e2_i),
    .rd_wb_i         (rd_wb_i),
    .result_wb_i     (result_wb_i),
    .div_busy_i      (r_div_busy),
    .div_rd_i        (r_div_rd),
    .value_o         (operand_ra_o),
    .hazard_o        (w_haz_ra)
  );

  biriscv_issue_fwd_mux #(
    .SUPPORT_LOAD_BYPASS (SUPPORT_LOAD_BYPASS),
    .SUPPORT_MUL_BYPASS  (SUPPORT_MUL_BYPASS)
  ) u_fwd_rb (
    .rs_i            (issue_rs2_i),
    .rf_data_i       (rf_rb_i),
    .load_e1_i       (load_e1_i),
    .mul_e1_i        (mul_e1_i),
    .rd_e1_i         (rd_e1_i),
    .alu_result_e1_i (alu_result_e1_i),
    .load_e2_i       (load_e2_i),
    .mul_e2_i        (mul_e2_i),
    .rd_e2_i         (rd_e2_i),
    .result_e2_i     (result_e2_i),
    .rd_wb_i         (rd_wb_i),
    .result_wb_i     (result_wb_i),
    .div_busy_i      (r_div_busy),
    .div_rd_i        (r_div_rd),
    .value_o         (operand_rb_o),
    .hazard_o        (w_haz_rb)
  );

  // Single divider: a second divide, or a write racing the pending one, must wait
  assign w_hazard = issue_valid_i & (
                      w_haz_ra | w_haz_rb |
                      (issue_div_i & r_div_busy) |
                      (issue_rd_valid_i & r_div_busy & (issue_rd_i == r_div_rd)));

  assign w_issue_fire = issue_valid_i & ~w_hazard & ~issue_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div_busy <= 1'b0;
      r_div_rd   <= '0;
    end else if (squash_e1_e2_i || div_complete_i) begin
      r_div_busy <= 1'b0;
    end else if (w_issue_fire && issue_div_i && !take_interrupt_i) begin
      r_div_busy <= 1'b1;
      r_div_rd   <= issue_rd_valid_i ? issue_rd_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_hazard_cycles <= 32'd0;
    else if (perf_clr_i)
      r_hazard_cycles <= 32'd0;
    else if (w_hazard && (r_hazard_cycles != 32'hFFFF_FFFF))
      r_hazard_cycles <= r_hazard_cycles + 32'd1;
  end

  assign issue_hazard_o  = w_hazard;
  assign div_busy_o      = r_div_busy;
  assign hazard_cycles_o = r_hazard_cycles;

endmodule
`default_nettype wire
